keypad_matrix_scan: RTL and testbench
=====================================

# keypad_matrix_scan

Drives a 4-row × 3-column membrane keypad, samples its columns, debounces whole-frame results and presents a stable 12-bit one-hot key code. It sits directly upstream of `keypad_scan`. Its `key_out` connects straight to `keypad_scan.keypad_in`, so the output is a level that is held while a key is pressed and is zero when no key is pressed. Only single-key presses are reported.

## Interface
- `SCAN_DIV`, default 1000: clk cycles each row is driven. Minimum 4.
- `DEBOUNCE_CNT`, default 4: number of consecutive identical frames required before `key_out` changes. Minimum 1.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `col_in`  in  3  keypad columns, active-low, externally pulled up, asynchronous to clk.
- `row_out`  out  4  keypad rows, active-low, one row low at a time.
- `key_out`  out  12  debounced one-hot key code, 0 = no key.
- `key_change`  out  1  one-cycle pulse in the cycle `key_out` takes a new value.

## Operation
- Key bit map: bits 0–8 = '1'..'9', bit 9 = '0', bit 10 = '*', bit 11 = '#'.
- Matrix layout:
  - row0: 1 2 3
  - row1: 4 5 6
  - row2: 7 8 9
  - row3: * 0 #
- For rows 0–2, key (r,c) maps to bit r*3+c. For row3, c0→bit10, c1→bit9, c2→bit11.
- `col_in` passes through a 2-flop synchronizer before any use.
- FSM states and row drive:
  - ROW0: `row_out`=1110.
  - ROW1: `row_out`=1101.
  - ROW2: `row_out`=1011.
  - ROW3: `row_out`=0111.
  - EVAL: `row_out`=1111.
- FSM transitions:
  - Each ROWn state lasts SCAN_DIV cycles, timed by a slot counter 0..SCAN_DIV-1.
  - EVAL lasts 1 cycle, then the FSM returns to ROW0.
  - Frame = 4*SCAN_DIV+1 cycles.
- Sampling: on slot count SCAN_DIV-1 of ROWn, the synchronized, inverted columns are ORed into `frame_code` at row n's bit positions.
- EVAL evaluation:
  - `candidate` = `frame_code` if `frame_code` has exactly one bit set, else 0. Multi-key frames therefore count as "no key".
  - If `candidate` == `last_cand`: `stable_cnt` increments, saturating at DEBOUNCE_CNT.
  - Otherwise: `last_cand` ← `candidate` and `stable_cnt` ← 1.
  - `frame_code` is cleared for the next frame.
- Output update: when the post-update `stable_cnt` ≥ DEBOUNCE_CNT and `last_cand` ≠ `key_out`, then `key_out` ← `last_cand` and `key_change` pulses.
- A change between two different keys without an intervening zero is allowed. It produces a single `key_change` pulse.

## Timing
- Reset values:
  - `row_out`=1110 (FSM in ROW0, slot 0).
  - `key_out`=0, `key_change`=0.
  - `frame_code`, `last_cand`, `stable_cnt` and synchronizer flops all 0.
- `key_out` and `key_change` are registered. Both update on the clock edge that ends EVAL. `key_change` is high for exactly that one following cycle.
- Column settle time per row = SCAN_DIV-3 cycles, because sampling uses pin values from 2 cycles earlier.
- Press latency: at most DEBOUNCE_CNT+1 frames from the pin transition to `key_out` update. The extra frame covers a partial first frame. Release latency is the same.
- `key_out` changes only at the EVAL boundary. It never changes mid-frame.
- Reset asserted mid-frame:
  - All state and outputs return to reset values immediately.
  - The partial frame is discarded.
  - A held key re-qualifies only after DEBOUNCE_CNT full frames.
- DEBOUNCE_CNT=1: every frame's `candidate` is reflected directly, with no filtering.

## Structure
- Package `keypad_pkg` holds:
  - Key bit-index constants KEY_0..KEY_9, KEY_STAR, KEY_HASH.
  - NUM_ROWS=4, NUM_COLS=3.
  - The FSM state enum.
  - A function mapping (row, col) to a bit index.
- Sub-module `keypad_frame_debounce`:
  - Inputs: `frame_code`, EVAL strobe.
  - Outputs: `key_out`, `key_change`.
  - Contains the `candidate`/`last_cand`/`stable_cnt` logic, so it can be reused by other scanners.
- Top level contains the synchronizer, row FSM, slot counter and `frame_code` accumulator.

## Test plan
All scenarios use SCAN_DIV=8 and DEBOUNCE_CNT=3, giving 33-cycle frames.
- Reset, no keys → `row_out` cycles 1110/1101/1011/0111 for 8 cycles each, then 1111 for 1 cycle; `key_out`=0; `key_change` never asserts.
- Hold '5' (col1 low whenever `row_out`=1101) → `key_out`=12'h010 within 4 frames with one `key_change` pulse. Release → `key_out`=0 within 4 frames with one pulse.
- Hold '#' (col2 low during row3), then '0' with no gap → `key_out` 12'h800, then 12'h200, with exactly two pulses.
- Press '2' only in alternate frames → `key_out` stays 0 and `key_change` never asserts.
- Hold '1' and '3' together → `key_out`=0 throughout. Release '3' → `key_out`=12'h001 after 3 stable frames.
- Hold '7', qualify, then pulse `rst` low mid-ROW2 → `key_out`=0 and `row_out`=1110 immediately. After release of reset, `key_out`=12'h040 after exactly 3 full frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, scan-state encoding and key-position mapping for the
// 4x3 membrane keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // Bit positions of each key inside the one-hot key code
  localparam int KEY_1    = 0;
  localparam int KEY_2    = 1;
  localparam int KEY_3    = 2;
  localparam int KEY_4    = 3;
  localparam int KEY_5    = 4;
  localparam int KEY_6    = 5;
  localparam int KEY_7    = 6;
  localparam int KEY_8    = 7;
  localparam int KEY_9    = 8;
  localparam int KEY_0    = 9;
  localparam int KEY_STAR = 10;
  localparam int KEY_HASH = 11;

  // One state per driven row, plus a single-cycle evaluation slot
  typedef enum logic [2:0] {
    ST_ROW0 = 3'd0,
    ST_ROW1 = 3'd1,
    ST_ROW2 = 3'd2,
    ST_ROW3 = 3'd3,
    ST_EVAL = 3'd4
  } scan_state_e;

  // Maps a matrix position to its key-code bit. The bottom row is not in
  // numeric order ('*' '0' '#'), so it is special-cased.
  function automatic int key_bit(input int row, input int col);
    int result;
    if (row < NUM_ROWS - 1) begin
      result = row * NUM_COLS + col;
    end else begin
      case (col)
        0:       result = KEY_STAR;
        1:       result = KEY_0;
        default: result = KEY_HASH;
      endcase
    end
    return result;
  endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Whole-frame debouncer: qualifies a single-key frame result after it has
// been seen in DEBOUNCE_CNT consecutive frames, then presents it as a level.
module keypad_frame_debounce
  import keypad_pkg::*;
#(
  parameter int WIDTH        = NUM_KEYS,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] frame_code,
  input  logic             eval_strobe,
  output logic [WIDTH-1:0] key_out,
  output logic             key_change
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] candidate;
  logic             one_hot;
  logic [WIDTH-1:0] last_cand_reg, last_cand_next;
  logic [CNT_W-1:0] stable_cnt_reg, stable_cnt_next;
  logic [WIDTH-1:0] key_out_reg, key_out_next;
  logic             key_change_reg, key_change_next;

  // Reduce the frame to a candidate key; several keys at once count as none
  always_comb begin
    one_hot   = (frame_code != '0) &&
                ((frame_code & (frame_code - WIDTH'(1))) == '0);
    candidate = one_hot ? frame_code : '0;
  end

  // Track how long the candidate has been stable and decide when to publish
  always_comb begin
    last_cand_next  = last_cand_reg;
    stable_cnt_next = stable_cnt_reg;
    key_out_next    = key_out_reg;
    key_change_next = 1'b0;
    if (eval_strobe) begin
      if (candidate == last_cand_reg) begin
        if (stable_cnt_reg < CNT_MAX) begin
          stable_cnt_next = stable_cnt_reg + CNT_ONE;
        end
      end else begin
        last_cand_next  = candidate;
        stable_cnt_next = CNT_ONE;
      end
      // Decision uses the post-update count so DEBOUNCE_CNT=1 passes through
      if ((stable_cnt_next >= CNT_MAX) && (last_cand_next != key_out_reg)) begin
        key_out_next    = last_cand_next;
        key_change_next = 1'b1;
      end
    end
  end

  // Debounce state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_cand_reg  <= '0;
      stable_cnt_reg <= '0;
      key_out_reg    <= '0;
      key_change_reg <= 1'b0;
    end else begin
      last_cand_reg  <= last_cand_next;
      stable_cnt_reg <= stable_cnt_next;
      key_out_reg    <= key_out_next;
      key_change_reg <= key_change_next;
    end
  end

  assign key_out    = key_out_reg;
  assign key_change = key_change_reg;

endmodule

// File: rtl/keypad_matrix_scan.sv
// 4x3 keypad scanner: drives one row low at a time, samples synchronized
// columns at the end of each row slot, accumulates a frame code and hands it
// to the frame debouncer once per frame.
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_out,
  output logic [NUM_KEYS-1:0] key_out,
  output logic                key_change
);

  localparam int               SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  logic [NUM_COLS-1:0] col_meta_reg;
  logic [NUM_COLS-1:0] col_sync_reg;
  scan_state_e         state_reg, state_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next;
  logic                slot_last;
  logic [NUM_ROWS-1:0] row_sel;
  logic                eval_strobe;
  logic [NUM_KEYS-1:0] sample_bits;
  logic [NUM_KEYS-1:0] frame_code_reg, frame_code_next;

  // Two-flop synchronizer for the asynchronous column pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_reg <= '0;
      col_sync_reg <= '0;
    end else begin
      col_meta_reg <= col_in;
      col_sync_reg <= col_meta_reg;
    end
  end

  assign slot_last = (slot_reg == SLOT_LAST);

  // Row FSM and slot counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_ROW0;
      slot_reg  <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
    end
  end

  // Next-state, row drive and evaluation strobe
  always_comb begin
    state_next  = state_reg;
    row_out     = '1;
    row_sel     = '0;
    eval_strobe = 1'b0;
    slot_next   = slot_last ? '0 : slot_reg + SLOT_ONE;
    case (state_reg)
      ST_ROW0: begin
        row_out = 4'b1110;
        row_sel = 4'b0001;
        if (slot_last) state_next = ST_ROW1;
      end
      ST_ROW1: begin
        row_out = 4'b1101;
        row_sel = 4'b0010;
        if (slot_last) state_next = ST_ROW2;
      end
      ST_ROW2: begin
        row_out = 4'b1011;
        row_sel = 4'b0100;
        if (slot_last) state_next = ST_ROW3;
      end
      ST_ROW3: begin
        row_out = 4'b0111;
        row_sel = 4'b1000;
        if (slot_last) state_next = ST_EVAL;
      end
      ST_EVAL: begin
        eval_strobe = 1'b1;
        slot_next   = '0;
        state_next  = ST_ROW0;
      end
      default: begin
        slot_next  = '0;
        state_next = ST_ROW0;
      end
    endcase
  end

  // Per-key sample: the active row's column reads low on the last slot
  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
      localparam int BIT = key_bit(gi, gc);
      assign sample_bits[BIT] = row_sel[gi] & slot_last & ~col_sync_reg[gc];
    end
  end

  // Frame accumulator: collect samples over the four rows, clear after EVAL
  always_comb begin
    frame_code_next = frame_code_reg | sample_bits;
    if (eval_strobe) begin
      frame_code_next = '0;
    end
  end

  // Frame code register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_code_reg <= '0;
    end else begin
      frame_code_reg <= frame_code_next;
    end
  end

  keypad_frame_debounce #(
    .WIDTH        (NUM_KEYS),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .frame_code  (frame_code_reg),
    .eval_strobe (eval_strobe),
    .key_out     (key_out),
    .key_change  (key_change)
  );

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Self-checking bench for keypad_matrix_scan: a keypad model drives the
// columns from the held-key set, a monitor collects every key_change event
// and each scenario compares them against the values it queued.
module tb_keypad_matrix_scan;

  localparam int SD    = 8;
  localparam int DC    = 3;
  localparam int FRAME = 4 * SD + 1;
  localparam int LAT   = (DC + 1) * FRAME + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  col_in;
  logic [3:0]  row_out;
  logic [11:0] key_out;
  logic        key_change;

  logic [11:0] held = '0;
  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  keypad_matrix_scan #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_in     (col_in),
    .row_out    (row_out),
    .key_out    (key_out),
    .key_change (key_change)
  );

  always #5 clk = ~clk;

  function automatic int kbit(input int r, input int c);
    if (r < 3) return r * 3 + c;
    if (c == 0) return 10;
    if (c == 1) return 9;
    return 11;
  endfunction

  // Keypad model: a held key pulls its column low while its row is driven
  always_comb begin
    col_in = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!row_out[r] && held[kbit(r, c)]) col_in[c] = 1'b0;
  end

  // Monitor: record each published key code
  always @(negedge clk) begin
    if (rst && key_change) begin
      pulses++;
      obs_q.push_back(key_out);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() > 0) break;
      tick(1);
    end
    ok = (obs_q.size() > 0);
  endtask

  task automatic wait_row(input logic [3:0] row, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (row_out == row) break;
      tick(1);
    end
    ok = (row_out == row);
  endtask

  task automatic test_reset;
    logic [3:0] er;
    rst = 1'b0;
    tick(2);
    total++; if (row_out !== 4'b1110) begin bad++; $display("FAIL reset_row: got %b want 1110", row_out); end
    total++; if (key_out !== 12'h000) begin bad++; $display("FAIL reset_key: got %h want 000", key_out); end
    total++; if (key_change !== 1'b0) begin bad++; $display("FAIL reset_chg: got %b want 0", key_change); end
    rst = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      er = (k < 4 * SD) ? ~(4'b0001 << (k / SD)) : 4'b1111;
      total++;
      if (row_out !== er) begin bad++; $display("FAIL row_seq[%0d]: got %b want %b", k, row_out, er); end
      tick(1);
    end
    tick(4 * FRAME);
    total++; if (key_out !== 12'h000) begin bad++; $display("FAIL idle_key: got %h want 000", key_out); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL idle_pulses: got %0d want 0", pulses); end
    $display("test_reset: row sequence and idle checked");
  endtask

  task automatic test_press_release;
    int          p0;
    bit          ok;
    logic [11:0] got, want;
    p0 = pulses;
    for (int s = 0; s < 2; s++) begin
      held = (s == 0) ? 12'h010 : 12'h000;
      exp_q.push_back(held);
      wait_obs(LAT, ok);
      want = exp_q.pop_front();
      total++;
      if (!ok) begin
        bad++; $display("FAIL key5_step%0d: no key_change, key_out=%h want %h", s, key_out, want);
      end else begin
        got = obs_q.pop_front();
        if (got !== want) begin bad++; $display("FAIL key5_step%0d: got %h want %h", s, got, want); end
        $display("key5 step%0d: key_out=%h", s, got);
      end
    end
    tick(2 * FRAME);
    total++; if (pulses - p0 !== 2) begin bad++; $display("FAIL key5_pulses: got %0d want 2", pulses - p0); end
  endtask

  task automatic test_back_to_back;
    int          p0;
    bit          ok;
    logic [11:0] got, want;
    logic [11:0] seq [3];
    seq[0] = 12'h800; seq[1] = 12'h200; seq[2] = 12'h000;
    p0 = pulses;
    for (int s = 0; s < 3; s++) begin
      held = seq[s];
      exp_q.push_back(seq[s]);
      wait_obs(LAT, ok);
      want = exp_q.pop_front();
      total++;
      if (!ok) begin
        bad++; $display("FAIL b2b_step%0d: no key_change, key_out=%h want %h", s, key_out, want);
      end else begin
        got = obs_q.pop_front();
        if (got !== want) begin bad++; $display("FAIL b2b_step%0d: got %h want %h", s, got, want); end
        $display("b2b step%0d: key_out=%h", s, got);
      end
      if (s == 1) begin
        total++; if (pulses - p0 !== 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses - p0); end
      end
    end
  endtask

  task automatic test_alternate;
    int p0;
    bit ok;
    p0 = pulses;
    wait_row(4'b1111, ok);
    total++; if (!ok) begin bad++; $display("FAIL alt_sync: row_out=%b want 1111", row_out); end
    for (int f = 0; f < 8; f++) begin
      held = (f % 2 == 0) ? 12'h002 : 12'h000;
      tick(FRAME);
      total++; if (key_out !== 12'h000) begin bad++; $display("FAIL alt_frame%0d: got %h want 000", f, key_out); end
    end
    held = '0;
    tick(FRAME);
    total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL alt_pulses: got %0d want 0", pulses - p0); end
    void'(obs_q.size());
    $display("test_alternate: key_out=%h pulses=%0d", key_out, pulses - p0);
  endtask

  task automatic test_multi_key;
    int          p0;
    bit          ok;
    logic [11:0] got, want;
    p0 = pulses;
    held = 12'h005;
    for (int f = 0; f < 5; f++) begin
      tick(FRAME);
      total++; if (key_out !== 12'h000) begin bad++; $display("FAIL multi_frame%0d: got %h want 000", f, key_out); end
    end
    total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL multi_pulses: got %0d want 0", pulses - p0); end
    for (int s = 0; s < 2; s++) begin
      held = (s == 0) ? 12'h001 : 12'h000;
      exp_q.push_back(held);
      wait_obs(LAT, ok);
      want = exp_q.pop_front();
      total++;
      if (!ok) begin
        bad++; $display("FAIL multi_step%0d: no key_change, key_out=%h want %h", s, key_out, want);
      end else begin
        got = obs_q.pop_front();
        if (got !== want) begin bad++; $display("FAIL multi_step%0d: got %h want %h", s, got, want); end
        $display("multi step%0d: key_out=%h", s, got);
      end
    end
  endtask

  task automatic test_reset_midframe;
    bit          ok;
    logic [11:0] got, want;
    held = 12'h040;
    exp_q.push_back(12'h040);
    wait_obs(LAT, ok);
    want = exp_q.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL rst7_qualify: no key_change, key_out=%h want %h", key_out, want);
    end else begin
      got = obs_q.pop_front();
      if (got !== want) begin bad++; $display("FAIL rst7_qualify: got %h want %h", got, want); end
    end
    wait_row(4'b1011, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst7_row2: row_out=%b want 1011", row_out); end
    tick(3);
    rst = 1'b0;
    #1;
    total++; if (key_out !== 12'h000) begin bad++; $display("FAIL rst7_key: got %h want 000", key_out); end
    total++; if (row_out !== 4'b1110) begin bad++; $display("FAIL rst7_row: got %b want 1110", row_out); end
    tick(2);
    exp_q.push_back(12'h040);
    rst = 1'b1;
    tick(3 * FRAME - 1);
    total++; if (key_out !== 12'h000) begin bad++; $display("FAIL rst7_early: got %h want 000", key_out); end
    tick(1);
    total++; if (key_out !== 12'h040) begin bad++; $display("FAIL rst7_requal: got %h want 040", key_out); end
    total++; if (key_change !== 1'b1) begin bad++; $display("FAIL rst7_chg: got %b want 1", key_change); end
    wait_obs(3, ok);
    want = exp_q.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL rst7_event: no key_change, key_out=%h want %h", key_out, want);
    end else begin
      got = obs_q.pop_front();
      if (got !== want) begin bad++; $display("FAIL rst7_event: got %h want %h", got, want); end
      $display("rst7 requalified: key_out=%h", got);
    end
    held = '0;
    exp_q.push_back(12'h000);
    wait_obs(LAT, ok);
    want = exp_q.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL rst7_release: no key_change, key_out=%h want %h", key_out, want);
    end else begin
      got = obs_q.pop_front();
      if (got !== want) begin bad++; $display("FAIL rst7_release: got %h want %h", got, want); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_press_release();
    test_back_to_back();
    test_alternate();
    test_multi_key();
    test_reset_midframe();
    total++;
    if (obs_q.size() !== 0) begin bad++; $display("FAIL leftover_events: got %0d want 0", obs_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
